pc_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the RISC-V core.
- Owns the architectural PC register and runs a fetch / execute / PC-update loop.
- Drives the instruction-memory request handshake and waits on datapath completion.
- Resolves the next PC from the 3-bit Branch code plus the zero/less flags, then commits it.

---
 rtl/pc_sequencer_if.sv | 43 ++++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: sequencer bus (fetch handshake, datapath handshake, status)
// master = sequencer side, slave = memory/datapath side.
// Macro PC_MISALIGN_TRAP_EN adds trap/trap_pc.
interface pc_sequencer_if;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [2:0]  Branch;
  logic        zero;
  logic        less;
  logic [31:0] imm;
  logic [31:0] rs1data;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        fetch_err;
  logic        halted;
`ifdef PC_MISALIGN_TRAP_EN
  logic        trap;
  logic [31:0] trap_pc;
  modport master (
    input  run, imem_ack, imem_rdata, exec_done, Branch, zero, less, imm, rs1data,
    output imem_req, imem_addr, instr, instr_valid, pc, retired, fetch_err, halted, trap, trap_pc
  );
  modport slave (
    output run, imem_ack, imem_rdata, exec_done, Branch, zero, less, imm, rs1data,
    input  imem_req, imem_addr, instr, instr_valid, pc, retired, fetch_err, halted, trap, trap_pc
  );
`else
  modport master (
    input  run, imem_ack, imem_rdata, exec_done, Branch, zero, less, imm, rs1data,
    output imem_req, imem_addr, instr, instr_valid, pc, retired, fetch_err, halted
  );
  modport slave (
    output run, imem_ack, imem_rdata, exec_done, Branch, zero, less, imm, rs1data,
    input  imem_req, imem_addr, instr, instr_valid, pc, retired, fetch_err, halted
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute/PC-update sequencer owning the PC.
// Ports: clk, rst (async active-high), bus (pc_sequencer_if.master).
// Macro PC_MISALIGN_TRAP_EN: misaligned next PC traps to HALT instead of
// being silently aligned.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t      r_state;
  logic [31:0] r_pc, r_instr, r_retired;
  logic        r_req, r_valid, r_err, r_halt;
  logic [7:0]  r_wait;
  logic        w_take, w_trap;
  logic [31:0] w_next, w_commit;
`ifdef PC_MISALIGN_TRAP_EN
  logic        r_trap;
  logic [31:0] r_trap_pc;
  assign bus.trap    = r_trap;
  assign bus.trap_pc = r_trap_pc;
  assign w_trap      = |w_next[1:0];
  assign w_commit    = w_next;
`else
  assign w_trap      = 1'b0;
  assign w_commit    = {w_next[31:2], 2'b00};
`endif
  // taken: jal, or a conditional branch whose condition holds
  assign w_take = (bus.Branch == 3'd1) |
                  (bus.Branch == 3'd4 &  bus.zero) | (bus.Branch == 3'd5 & ~bus.zero) |
                  (bus.Branch == 3'd6 &  bus.less) | (bus.Branch == 3'd7 & ~bus.less);
  assign w_next = (bus.Branch == 3'd2) ? ((bus.rs1data + bus.imm) & ~32'd1) :
                  w_take ? r_pc + bus.imm : r_pc + 32'd4;
  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.pc          = r_pc;
  assign bus.retired     = r_retired;
  assign bus.fetch_err   = r_err;
  assign bus.halted      = r_halt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_halt    <= 1'b0;
      r_wait    <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      r_trap    <= 1'b0;
      r_trap_pc <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (bus.run) begin
          r_state <= FETCH;
          r_req   <= 1'b1;
        end
        FETCH: if (bus.imem_ack) begin
          r_instr <= bus.imem_rdata;
          r_wait  <= '0;
          r_req   <= 1'b0;
          r_valid <= 1'b1;
          r_state <= EXEC;
        end else if (r_wait == 8'(FETCH_TIMEOUT - 1)) begin
          r_err   <= 1'b1;
          r_req   <= 1'b0;
          r_halt  <= 1'b1;
          r_state <= HALT;
        end else begin
          r_wait  <= r_wait + 8'd1;
        end
        EXEC: if (bus.exec_done) begin
          r_valid <= 1'b0;
          if (w_trap) begin
`ifdef PC_MISALIGN_TRAP_EN
            r_trap    <= 1'b1;
            r_trap_pc <= w_next;
`endif
            r_halt  <= 1'b1;
            r_state <= HALT;
          end else begin
            r_pc      <= w_commit;
            r_retired <= r_retired + 32'd1;
            r_req     <= bus.run;
            r_state   <= bus.run ? FETCH : IDLE;
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ack_mode = 1'b1;
  logic ack_force = 1'b0;
  int checks = 0;
  int failures = 0;
  pc_sequencer_if bus();
  assign bus.imem_ack   = ack_mode ? bus.imem_req : ack_force;
  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;
  pc_sequencer #(.RESET_PC(32'h100), .FETCH_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [2:0]  t_b   [13] = '{3'd1, 3'd4, 3'd2, 3'd4, 3'd2, 3'd2, 3'd7, 3'd5, 3'd6, 3'd7, 3'd3, 3'd6, 3'd5};
  logic        t_z   [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        t_l   [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] t_imm [13] = '{32'hF8, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'h4, 32'h0, 32'h8,
                              32'h10, 32'hFFFF_FFF8, 32'h100, 32'h100, 32'h100, 32'h100};
  logic [31:0] t_rs  [13] = '{32'h0, 32'h0, 32'h200, 32'h0, 32'h1001, 32'h40, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] t_exp [13] = '{32'h200, 32'h1F0, 32'h200, 32'h204, 32'h1004, 32'h40, 32'h48,
                              32'h58, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h60};
  task automatic do_exec(input logic [2:0] b, input logic z, input logic l,
                         input logic [31:0] im, input logic [31:0] rs);
    for (int i = 0; i < 20 && !bus.instr_valid; i++) @(negedge clk);
    checks++;
    if (!bus.instr_valid) begin
      failures++;
      $display("FAIL exec_wait instr_valid=%b required=1", bus.instr_valid);
    end
    bus.Branch = b; bus.zero = z; bus.less = l; bus.imm = im; bus.rs1data = rs;
    bus.exec_done = 1'b1;
    @(negedge clk);
    bus.exec_done = 1'b0;
  endtask
  task automatic test_reset;
    bus.run = 1'b1; bus.exec_done = 1'b0; bus.Branch = '0; bus.zero = 1'b0;
    bus.less = 1'b0; bus.imm = '0; bus.rs1data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.pc !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h100); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.retired !== 32'h0) begin failures++; $display("FAIL reset_retired got=%h exp=0", bus.retired); end
    checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instr); end
    checks++; if ({bus.instr_valid, bus.fetch_err, bus.halted} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.instr_valid, bus.fetch_err, bus.halted}); end
`ifdef PC_MISALIGN_TRAP_EN
    checks++; if ({bus.trap, bus.trap_pc} !== 33'h0) begin failures++; $display("FAIL reset_trap got=%b/%h exp=0/0", bus.trap, bus.trap_pc); end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin failures++; $display("FAIL first_fetch req=%b addr=%h exp=1/100", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL first_exec valid=%b req=%b exp=1/0", bus.instr_valid, bus.imem_req); end
    checks++; if (bus.instr !== 32'hA5A5_0100) begin failures++; $display("FAIL first_instr got=%h exp=a5a50100", bus.instr); end
  endtask
  task automatic test_sequential;
    do_exec(3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_exec(3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (bus.pc !== 32'h108) begin failures++; $display("FAIL seq_pc got=%h exp=108", bus.pc); end
    checks++; if (bus.retired !== 32'd2) begin failures++; $display("FAIL seq_retired got=%0d exp=2", bus.retired); end
  endtask
  task automatic test_branches;
    for (int i = 0; i < 13; i++) begin
      do_exec(t_b[i], t_z[i], t_l[i], t_imm[i], t_rs[i]);
      checks++;
      if (bus.pc !== t_exp[i]) begin failures++; $display("FAIL branch_%0d pc got=%h exp=%h", i, bus.pc, t_exp[i]); end
    end
    checks++; if (bus.retired !== 32'd15) begin failures++; $display("FAIL branch_retired got=%0d exp=15", bus.retired); end
  endtask
  task automatic test_run_drop;
    ack_mode = 1'b0; ack_force = 1'b0; bus.run = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h60) begin failures++; $display("FAIL drop_hold req=%b addr=%h exp=1/60", bus.imem_req, bus.imem_addr); end
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL drop_exec valid=%b req=%b exp=1/0", bus.instr_valid, bus.imem_req); end
    checks++; if (bus.instr !== 32'hA5A5_0060) begin failures++; $display("FAIL drop_instr got=%h exp=a5a50060", bus.instr); end
    do_exec(3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (bus.pc !== 32'h64) begin failures++; $display("FAIL drop_pc got=%h exp=64", bus.pc); end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL drop_idle req=%b valid=%b exp=0/0", bus.imem_req, bus.instr_valid); end
    checks++; if (bus.retired !== 32'd16) begin failures++; $display("FAIL drop_retired got=%0d exp=16", bus.retired); end
  endtask
  task automatic test_misalign;
    ack_mode = 1'b1; bus.run = 1'b1;
    do_exec(3'd2, 1'b0, 1'b0, 32'h0, 32'h10);
    checks++; if (bus.pc !== 32'h10) begin failures++; $display("FAIL mis_setup pc got=%h exp=10", bus.pc); end
    do_exec(3'd1, 1'b0, 1'b0, 32'h6, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    checks++; if (bus.trap !== 1'b1 || bus.trap_pc !== 32'h16) begin failures++; $display("FAIL mis_trap trap=%b trap_pc=%h exp=1/16", bus.trap, bus.trap_pc); end
    checks++; if (bus.pc !== 32'h10 || bus.retired !== 32'd17) begin failures++; $display("FAIL mis_hold pc=%h retired=%0d exp=10/17", bus.pc, bus.retired); end
    checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL mis_halt got=%b exp=1", bus.halted); end
`else
    checks++; if (bus.pc !== 32'h14 || bus.retired !== 32'd18) begin failures++; $display("FAIL mis_align pc=%h retired=%0d exp=14/18", bus.pc, bus.retired); end
`endif
  endtask
  task automatic test_timeout;
    rst = 1'b1; ack_mode = 1'b0; ack_force = 1'b0; bus.run = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.pc !== 32'h100) begin failures++; $display("FAIL async_reset req=%b pc=%h exp=0/100", bus.imem_req, bus.pc); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL to_req got=%b exp=1", bus.imem_req); end
    repeat (3) @(negedge clk);
    checks++; if (bus.fetch_err !== 1'b0 || bus.halted !== 1'b0) begin failures++; $display("FAIL to_early err=%b halted=%b exp=0/0", bus.fetch_err, bus.halted); end
    @(negedge clk);
    checks++; if ({bus.fetch_err, bus.halted, bus.imem_req} !== 3'b110) begin failures++; $display("FAIL to_halt err/halt/req got=%b exp=110", {bus.fetch_err, bus.halted, bus.imem_req}); end
    ack_force = 1'b1; bus.exec_done = 1'b1;
    repeat (3) @(negedge clk);
    ack_force = 1'b0; bus.exec_done = 1'b0;
    @(negedge clk);
    checks++; if ({bus.fetch_err, bus.halted, bus.imem_req, bus.instr_valid} !== 4'b1100) begin failures++; $display("FAIL halt_sticky got=%b exp=1100", {bus.fetch_err, bus.halted, bus.imem_req, bus.instr_valid}); end
    checks++; if (bus.pc !== 32'h100 || bus.retired !== 32'd0 || bus.instr !== 32'h0) begin failures++; $display("FAIL halt_state pc=%h retired=%0d instr=%h exp=100/0/0", bus.pc, bus.retired, bus.instr); end
  endtask
  initial begin
    test_reset;
    test_sequential;
    test_branches;
    test_run_drop;
    test_misalign;
    test_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
